wts_wave_mixer: RTL

- Consumer end of the per-channel wave-address/envelope interface.
- Once per `active` sample tick, it scans CH_NUM channel parts in order. For each channel it issues that channel's 7-bit wave address to the shared wave SRAM, reads the signed 8-bit sample, scales it by the channel's 9-bit envelope, and accumulates the result.
- The finished sum is published as one signed 16-bit mixed sample.
- The block also owns the SRAM write side: CPU wave-table writes are buffered and issued in idle slots.

---
 rtl/wts_wave_mixer.sv | 113 +++++++++++
 1 files changed

// File: rtl/wts_wave_mixer.sv
// Wave-table mixer: once per active tick, scans CH_NUM channels through the shared
// wave SRAM, scales each sample by its envelope and publishes the 16-bit mixed sum.
module wts_wave_mixer #(
  parameter int CH_NUM  = 5,
  parameter int CH_BITS = 3
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               active,
  output logic [CH_BITS-1:0] ch_sel,
  input  logic [6:0]         ch_sram_a,
  input  logic [8:0]         ch_envelope,
  output logic [CH_BITS+6:0] sram_a,
  output logic               sram_we,
  output logic [7:0]         sram_d,
  input  logic [7:0]         sram_q,
  input  logic               cpu_wr,
  input  logic [CH_BITS+6:0] cpu_a,
  input  logic [7:0]         cpu_d,
  output logic               cpu_busy,
  output logic [15:0]        sound_out,
  output logic               sound_valid
);

  // state | meaning
  // IDLE  | waiting for active; issues a buffered CPU write when one is pending
  // ADDR  | read address {ch, ch_sram_a} on the SRAM, envelope captured
  // DATA  | sram_q valid; product accumulated, advance channel or finish
  // DONE  | sound_out/sound_valid visible for one clk, back to IDLE
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [CH_BITS-1:0] CH_LAST = CH_BITS'(CH_NUM - 1);

  state_t             state;
  logic [CH_BITS+6:0] buf_a;
  logic [CH_BITS+6:0] hold_a;
  logic [8:0]         env_q;
  logic signed [19:0] acc;
  logic signed [17:0] samp_x;
  logic signed [17:0] env_x;
  logic signed [17:0] prod;
  logic signed [19:0] prod_x;
  logic signed [19:0] acc_next;
  logic               write_go;

  assign samp_x   = 18'($signed(sram_q));
  assign env_x    = 18'({1'b0, env_q});
  assign prod     = samp_x * env_x;
  assign prod_x   = {{2{prod[17]}}, prod};
  assign acc_next = (ch_sel == '0) ? prod_x : acc + prod_x;

  // The channel mux is external, so the read address must follow ch_sel in the same cycle.
  assign write_go = nreset && (state == IDLE) && cpu_busy && !active;
  assign sram_we  = write_go;
  assign sram_a   = (state == ADDR) ? {ch_sel, ch_sram_a} : (write_go ? buf_a : hold_a);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= IDLE;
      ch_sel      <= '0;
      buf_a       <= '0;
      hold_a      <= '0;
      sram_d      <= '0;
      cpu_busy    <= 1'b0;
      env_q       <= '0;
      acc         <= '0;
      sound_out   <= '0;
      sound_valid <= 1'b0;
    end else begin
      sound_valid <= 1'b0;

      if (write_go)
        cpu_busy <= 1'b0;
      else if (cpu_wr && !cpu_busy) begin
        cpu_busy <= 1'b1;
        buf_a    <= cpu_a;
        sram_d   <= cpu_d;
      end

      case (state)
        IDLE: begin
          if (active) begin
            state  <= ADDR;
            ch_sel <= '0;
          end
        end
        ADDR: begin
          hold_a <= {ch_sel, ch_sram_a};
          env_q  <= ch_envelope;
          state  <= DATA;
        end
        DATA: begin
          acc <= acc_next;
          // Result is registered on the way into DONE so it is visible during DONE.
          if (ch_sel == CH_LAST) begin
            state       <= DONE;
            sound_out   <= acc_next[18:3];
            sound_valid <= 1'b1;
          end else begin
            ch_sel <= ch_sel + 1'b1;
            state  <= ADDR;
          end
        end
        DONE: begin
          ch_sel <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
